inst_rom_resp: RTL and testbench

- Responder side of the core's instruction-fetch interface: answers chip-enable and byte-address with a 32-bit instruction word.
- Holds a 2^AW-word instruction array. The array is filled after reset by a byte-serial valid/ready loader, big-endian, at sequential word addresses.
- Holds the core in reset through cpu_rst_o until loading completes; the core then fetches with zero wait states.

---
 rtl/inst_rom_resp.sv | 117 +++++++++++
 tb/tb_inst_rom_resp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: a byte-serial loader fills the array big-endian
// after reset, the core is held in reset until loading completes, and the core
// then fetches with zero wait states through an asynchronous read port.
module inst_rom_resp #(
  parameter int AW     = 10,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              load_done_o,
  output logic              cpu_rst_o,
  output logic [AW:0]       words_loaded_o
);

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [AW:0] WORDS_MAX = (AW+1)'(1) << AW;

  state_t            r_state;
  logic [1:0]        r_byteIdx;
  logic [AW-1:0]     r_wordPtr;
  logic [INST_W-1:0] r_shift;
  logic [AW:0]       r_wordsLoaded;
  logic [INST_W-1:0] r_mem [2**AW];

  logic              w_accept;
  logic              w_wordEnd;
  logic              w_hiZero;
  logic [INST_W-1:0] w_assembled;

  // Ready only while loading and out of reset; a word closes on lane 3 or on the last byte
  always_comb begin
    ld_ready_o = (r_state == LOAD) && rst;
    w_accept   = ld_valid_i && ld_ready_o;
    w_wordEnd  = w_accept && ((r_byteIdx == 2'd3) || ld_last_i);
  end

  // Drop the incoming byte into its big-endian lane on top of the bytes already held
  always_comb begin
    w_assembled = r_shift;
    case (r_byteIdx)
      2'd0:    w_assembled[31:24] = ld_byte_i;
      2'd1:    w_assembled[23:16] = ld_byte_i;
      2'd2:    w_assembled[15:8]  = ld_byte_i;
      default: w_assembled[7:0]   = ld_byte_i;
    endcase
  end

  // Loader FSM: assembles bytes into words and advances the word pointer until the image ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= LOAD;
      r_byteIdx     <= 2'd0;
      r_wordPtr     <= '0;
      r_shift       <= '0;
      r_wordsLoaded <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (w_wordEnd) begin
              r_shift   <= '0;
              r_byteIdx <= 2'd0;
              r_wordPtr <= r_wordPtr + 1'b1;
              if (r_wordsLoaded != WORDS_MAX) begin
                r_wordsLoaded <= r_wordsLoaded + 1'b1;
              end
              if (ld_last_i || (r_wordPtr == '1)) begin
                r_state <= DONE;
              end
            end else begin
              r_shift   <= w_assembled;
              r_byteIdx <= r_byteIdx + 2'd1;
            end
          end
        end
        default: begin
          r_state <= DONE;
        end
      endcase
    end
  end

  // Single write port, fed only by the loader; contents survive reset so no reset branch
  always_ff @(posedge clk) begin
    if (w_wordEnd) begin
      r_mem[r_wordPtr] <= w_assembled;
    end
  end

  // Status outputs come straight from the state register so they switch on the same edge
  always_comb begin
    load_done_o    = (r_state == DONE);
    cpu_rst_o      = (r_state == LOAD);
    words_loaded_o = r_wordsLoaded;
  end

  // Zero-latency fetch; anything outside the array or before load completion reads as zero
  always_comb begin
    w_hiZero   = (rom_addr_i >> (AW + 2)) == 32'd0;
    rom_data_o = '0;
    if (rom_ce_i && w_hiZero && load_done_o) begin
      rom_data_o = r_mem[rom_addr_i[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Testbench for inst_rom_resp: one instance at the default depth and one small
// instance (AW=2) to reach the full-array boundary; a byte-level model pushes
// expected words to a queue that is drained through the fetch port.
module tb_inst_rom_resp;

  logic        clk;
  logic        rst;

  logic        romCe10;
  logic [31:0] romAddr10;
  logic [31:0] romData10;
  logic        ldValid10;
  logic [7:0]  ldByte10;
  logic        ldLast10;
  logic        ldReady10;
  logic        loadDone10;
  logic        cpuRst10;
  logic [10:0] wordsLoaded10;

  logic        romCe2;
  logic [31:0] romAddr2;
  logic [31:0] romData2;
  logic        ldValid2;
  logic [7:0]  ldByte2;
  logic        ldLast2;
  logic        ldReady2;
  logic        loadDone2;
  logic        cpuRst2;
  logic [2:0]  wordsLoaded2;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  logic [31:0] expQ[$];
  logic [31:0] modelMem10 [int];
  logic [31:0] modelMem2 [int];
  int          mK;
  logic [31:0] mWord;
  int          mPtr;
  int          mCap;
  bit          mDone;

  inst_rom_resp #(.AW(10), .INST_W(32)) dut10 (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_i       (romCe10),
    .rom_addr_i     (romAddr10),
    .rom_data_o     (romData10),
    .ld_valid_i     (ldValid10),
    .ld_byte_i      (ldByte10),
    .ld_last_i      (ldLast10),
    .ld_ready_o     (ldReady10),
    .load_done_o    (loadDone10),
    .cpu_rst_o      (cpuRst10),
    .words_loaded_o (wordsLoaded10)
  );

  inst_rom_resp #(.AW(2), .INST_W(32)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_i       (romCe2),
    .rom_addr_i     (romAddr2),
    .rom_data_o     (romData2),
    .ld_valid_i     (ldValid2),
    .ld_byte_i      (ldByte2),
    .ld_last_i      (ldLast2),
    .ld_ready_o     (ldReady2),
    .load_done_o    (loadDone2),
    .cpu_rst_o      (cpuRst2),
    .words_loaded_o (wordsLoaded2)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every comparison and reports any that disagree
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous response, releases it and resets the model
  task automatic resetAll(input int cap);
    rst = 1'b0;
    #1;
    checkOutput("rst_cpuRst10", 64'(cpuRst10), 64'd1);
    checkOutput("rst_done10", 64'(loadDone10), 64'd0);
    checkOutput("rst_words10", 64'(wordsLoaded10), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    mK    = 0;
    mWord = 32'd0;
    mPtr  = 0;
    mCap  = cap;
    mDone = 1'b0;
    expQ.delete();
  endtask

  // Presents one valid byte for one edge and advances the model if the byte is accepted
  task automatic applyStimulus(input logic [7:0] b, input bit last, input bit sel);
    logic [31:0] lane;
    if (sel) begin
      ldValid2 = 1'b1; ldByte2 = b; ldLast2 = last;
    end else begin
      ldValid10 = 1'b1; ldByte10 = b; ldLast10 = last;
    end
    if (!mDone) begin
      lane  = {b, 24'h0};
      mWord = mWord | (lane >> (8 * mK));
      if ((mK == 3) || last) begin
        expQ.push_back(mWord);
        if (sel) modelMem2[mPtr] = mWord;
        else     modelMem10[mPtr] = mWord;
        mPtr++;
        mK    = 0;
        mWord = 32'd0;
        if (last || (mPtr == mCap)) mDone = 1'b1;
      end else begin
        mK++;
      end
    end
    @(posedge clk);
    #1;
    ldValid10 = 1'b0; ldLast10 = 1'b0;
    ldValid2  = 1'b0; ldLast2  = 1'b0;
  endtask

  // Idle cycles with a junk byte on the bus but valid low
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      ldByte10 = 8'($urandom);
      ldByte2  = 8'($urandom);
      ldLast10 = 1'($urandom);
      @(posedge clk);
      #1;
      ldLast10 = 1'b0;
    end
  endtask

  // Combinational fetch through either instance
  task automatic readWord(input bit sel, input bit ce, input logic [31:0] addr, output logic [31:0] data);
    if (sel) begin
      romCe2 = ce; romAddr2 = addr;
    end else begin
      romCe10 = ce; romAddr10 = addr;
    end
    #1;
    data = sel ? romData2 : romData10;
    romCe10 = 1'b0; romCe2 = 1'b0;
  endtask

  // Pops each expected word and compares it with the fetched word at the matching address
  task automatic drainQueue(input bit sel, input string tag);
    logic [31:0] got;
    logic [31:0] want;
    int idx;
    idx = 0;
    while (expQ.size() > 0) begin
      want = expQ.pop_front();
      readWord(sel, 1'b1, 32'(idx * 4), got);
      checkOutput($sformatf("%s_mem%0d", tag, idx), 64'(got), 64'(want));
      idx++;
    end
  endtask

  logic [7:0]  s1Bytes [8];
  logic [7:0]  s2Bytes [5];
  logic [7:0]  s6Bytes [4];
  logic [31:0] rd;

  initial begin
    s1Bytes = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
    s2Bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    s6Bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    romCe10 = 1'b0; romAddr10 = 32'd0; ldValid10 = 1'b0; ldByte10 = 8'd0; ldLast10 = 1'b0;
    romCe2  = 1'b0; romAddr2  = 32'd0; ldValid2  = 1'b0; ldByte2  = 8'd0; ldLast2  = 1'b0;
    #2;

    // Two-word image with last on byte 8
    resetAll(1024);
    checkOutput("s1_ready", 64'(ldReady10), 64'd1);
    readWord(1'b0, 1'b1, 32'h0, rd);
    checkOutput("s1_fetchEmpty", 64'(rd), 64'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s1Bytes[i], (i == 7), 1'b0);
      if (i == 3) begin
        checkOutput("s1_words1", 64'(wordsLoaded10), 64'd1);
        readWord(1'b0, 1'b1, 32'h0, rd);
        checkOutput("s1_fetchWhileLoad", 64'(rd), 64'd0);
      end
      if (i == 6) begin
        checkOutput("s1_doneEarly", 64'(loadDone10), 64'd0);
        checkOutput("s1_cpuRstEarly", 64'(cpuRst10), 64'd1);
      end
    end
    checkOutput("s1_done", 64'(loadDone10), 64'd1);
    checkOutput("s1_cpuRst", 64'(cpuRst10), 64'd0);
    checkOutput("s1_readyDone", 64'(ldReady10), 64'd0);
    checkOutput("s1_words", 64'(wordsLoaded10), 64'(mPtr));
    drainQueue(1'b0, "s1");

    // Short final word padded with zero lanes
    resetAll(1024);
    for (int i = 0; i < 5; i++) applyStimulus(s2Bytes[i], (i == 4), 1'b0);
    checkOutput("s2_done", 64'(loadDone10), 64'd1);
    checkOutput("s2_words", 64'(wordsLoaded10), 64'd2);
    drainQueue(1'b0, "s2");

    // Valid toggling: idle cycles between bytes must not count
    resetAll(1024);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s1Bytes[i], (i == 7), 1'b0);
      if (i != 7) idleCycles(1);
    end
    checkOutput("s3_done", 64'(loadDone10), 64'd1);
    checkOutput("s3_words", 64'(wordsLoaded10), 64'd2);
    drainQueue(1'b0, "s3");

    // Fetch gating after load: chip-enable off, out-of-range, low address bits ignored
    readWord(1'b0, 1'b0, 32'h0, rd);
    checkOutput("s5_ceOff", 64'(rd), 64'd0);
    readWord(1'b0, 1'b1, 32'h0000_1000, rd);
    checkOutput("s5_outOfRange", 64'(rd), 64'd0);
    readWord(1'b0, 1'b1, 32'h0000_0002, rd);
    checkOutput("s5_lowBits", 64'(rd), 64'(modelMem10[0]));
    readWord(1'b0, 1'b1, 32'h0000_0007, rd);
    checkOutput("s5_lowBits1", 64'(rd), 64'(modelMem10[1]));

    // Small array filled with no last flag; extra bytes dropped
    resetAll(4);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b0, 1'b1);
      if (i == 14) checkOutput("s4_doneBefore16", 64'(loadDone2), 64'd0);
      if (i == 15) checkOutput("s4_doneAt16", 64'(loadDone2), 64'd1);
    end
    checkOutput("s4_ready", 64'(ldReady2), 64'd0);
    checkOutput("s4_words", 64'(wordsLoaded2), 64'd4);
    checkOutput("s4_cpuRst", 64'(cpuRst2), 64'd0);
    drainQueue(1'b1, "s4");
    readWord(1'b1, 1'b1, 32'h0000_0010, rd);
    checkOutput("s4_outOfRange", 64'(rd), 64'd0);

    // Reset mid-load, then reload a single word
    resetAll(1024);
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hC0 + i), 1'b0, 1'b0);
    checkOutput("s6_cpuRstLoading", 64'(cpuRst10), 64'd1);
    checkOutput("s6_words1", 64'(wordsLoaded10), 64'd1);
    resetAll(1024);
    for (int i = 0; i < 4; i++) applyStimulus(s6Bytes[i], (i == 3), 1'b0);
    checkOutput("s6_done", 64'(loadDone10), 64'd1);
    checkOutput("s6_words", 64'(wordsLoaded10), 64'd1);
    drainQueue(1'b0, "s6");
    readWord(1'b0, 1'b1, 32'h0000_0004, rd);
    checkOutput("s6_retained", 64'(rd), 64'(modelMem10[1]));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
